// File: rtl/pdm_decimator.sv
// pdm_decimator: converts the asynchronous 1-bit OTA pulse-density stream into
//   OUT_W-bit sample words by counting ones over 2^OSR_LOG2 cycles
//   (accumulate-and-dump). The result goes out through a single-entry valid/ready buffer.
// Latency: 2 cycles synchroniser to count; 2 cycles last counted sample to sample_valid.
// Backpressure: while the buffer is full and not accepted, a newly completed result is
//   dropped and the sticky overrun flag is set. A transfer clears overrun.
// Ports: clk, rst (async active-high), en, pdm_in, pdm_drv (both async inputs),
//   sample_data/sample_valid/sample_ready (output handshake), overrun (sticky flag).
// Option: define PDM_DEC_HOLD_EN so that undriven cycles (s_drv=0) count the last
//   driven bit, which models the OTA keeper. Without it, undriven cycles count as 0.
module pdm_decimator #(
  parameter int OSR_LOG2 = 8,
  parameter int OUT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pdm_in,
  input  logic             pdm_drv,
  output logic [OUT_W-1:0] sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun
);

  localparam int CNT_W  = OSR_LOG2;
  localparam int ONES_W = OSR_LOG2 + 1;
  localparam int SHIFT  = OSR_LOG2 - OUT_W;

  typedef enum logic [1:0] {IDLE, ACCUM, DUMP} state_t;

  // Two-flop synchronisers; bit [1] is the synchronised copy.
  logic [1:0]        sync_bit_q, sync_bit_d;
  logic [1:0]        sync_drv_q, sync_drv_d;
  logic              s_bit, s_drv, eff;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic [OUT_W-1:0]  res_q, res_d;
  logic              res_vld_q, res_vld_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic [ONES_W-1:0] ones_shift;
  logic [OUT_W-1:0]  scaled;
  logic              xfer;

  assign s_bit = sync_bit_q[1];
  assign s_drv = sync_drv_q[1];

  always_comb begin
    sync_bit_d = {sync_bit_q[0], pdm_in};
    sync_drv_d = {sync_drv_q[0], pdm_drv};
  end

`ifdef PDM_DEC_HOLD_EN
  logic last_drv_q, last_drv_d;

  always_comb begin
    last_drv_d = s_drv ? s_bit : last_drv_q;
    eff        = s_drv ? s_bit : last_drv_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_drv_q <= 1'b0;
    else     last_drv_q <= last_drv_d;
  end
`else
  always_comb eff = s_drv & s_bit;
`endif

  // A full window of ones (top bit set) saturates instead of wrapping to zero.
  assign ones_shift = ones_q >> SHIFT;
  assign scaled     = ones_q[ONES_W-1] ? {OUT_W{1'b1}} : ones_shift[OUT_W-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ones_d    = ones_q;
    res_d     = res_q;
    res_vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        ones_d = '0;
        if (en) state_d = ACCUM;
      end
      ACCUM: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          ones_d  = '0;
        end else begin
          ones_d = ones_q + ONES_W'(eff);
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == {CNT_W{1'b1}}) state_d = DUMP;
        end
      end
      DUMP: begin
        // The result is captured even if en has fallen. This cycle's sample
        // opens the next window, so continuous conversion loses no samples.
        res_d     = scaled;
        res_vld_d = 1'b1;
        if (en) begin
          state_d = ACCUM;
          ones_d  = ONES_W'(eff);
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = IDLE;
          ones_d  = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ones_d  = '0;
      end
    endcase
  end

  // Output buffer. A result can load into a slot that drains this cycle.
  // A result that meets a full, stalled slot is dropped and raises overrun.
  assign xfer = valid_q & sample_ready;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (xfer) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (res_vld_q) begin
      if (!valid_q || xfer) begin
        data_d  = res_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_bit_q <= '0;
      sync_drv_q <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      ones_q     <= '0;
      res_q      <= '0;
      res_vld_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_bit_q <= sync_bit_d;
      sync_drv_q <= sync_drv_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ones_q     <= ones_d;
      res_q      <= res_d;
      res_vld_q  <= res_vld_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: directed test of pdm_decimator with default parameters.
// Inputs change 1 time unit after each rising edge, and outputs are sampled at that point.
module tb_pdm_decimator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       pdm_in = 1'b0;
  logic       pdm_drv = 1'b0;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       sample_ready = 1'b0;
  logic       overrun;

  int  tests = 0;
  int  fails = 0;
  bit  alt = 1'b0;

`ifdef PDM_DEC_HOLD_EN
  localparam logic [7:0] HOLD_EXP = 8'hFF;
`else
  localparam logic [7:0] HOLD_EXP = 8'h40;
`endif

  pdm_decimator #(.OSR_LOG2(8), .OUT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .pdm_in       (pdm_in),
    .pdm_drv      (pdm_drv),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (alt) pdm_in = ~pdm_in;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // Advance until sample_valid is seen; n is the number of edges taken.
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sample_valid && n < 400);
    chk(tag, sample_valid, 1'b1);
  endtask

  initial begin
    int  n;
    bit  seen;

    // Reset state
    #2;
    chk("rst_data", sample_data, 8'h00);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    tick();
    rst = 1'b0;

    // All ones, ready=1: saturated results every 256 cycles
    pdm_in = 1'b1; pdm_drv = 1'b1; sample_ready = 1'b1;
    ticks(4);
    en = 1'b1;
    wait_valid("ones_to1", n);
    chk("first_latency", n, 259);
    chk("ones_w1", sample_data, 8'hFF);
    wait_valid("ones_to2", n);
    chk("period", n, 256);
    chk("ones_w2", sample_data, 8'hFF);
    chk("ones_ovr", overrun, 1'b0);

    // Alternating input: skip the mixed window, then expect half scale
    alt = 1'b1;
    wait_valid("alt_skip", n);
    wait_valid("alt_to", n);
    chk("alt_data", sample_data, 8'h80);

    // All zeros
    alt = 1'b0; pdm_in = 1'b0;
    wait_valid("zero_skip", n);
    wait_valid("zero_to", n);
    chk("zero_data", sample_data, 8'h00);

    // 64 driven ones, then undriven for the rest of the window
    en = 1'b0; pdm_in = 1'b1; pdm_drv = 1'b1;
    ticks(4);
    en = 1'b1;
    tick();            // edge that moves IDLE -> ACCUM
    ticks(62);
    pdm_drv = 1'b0;    // first undriven value becomes counted sample 65
    wait_valid("hold_to", n);
    chk("hold_data", sample_data, HOLD_EXP);
    en = 1'b0;
    pdm_drv = 1'b1;

    // Partial window discarded, next full window is fresh
    ticks(4);
    en = 1'b1;
    ticks(100);
    en = 1'b0;
    alt = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (sample_valid) seen = 1'b1;
    end
    chk("partial_none", seen, 1'b0);
    en = 1'b1;
    wait_valid("fresh_to", n);
    chk("fresh_data", sample_data, 8'h80);
    chk("fresh_latency", n, 259);

    // Backpressure: first result held, second dropped with overrun
    en = 1'b0; alt = 1'b0; pdm_in = 1'b1;
    ticks(4);
    sample_ready = 1'b0;
    chk("bp_empty", sample_valid, 1'b0);
    en = 1'b1;
    wait_valid("bp_to", n);
    chk("bp_first", sample_data, 8'hFF);
    pdm_in = 1'b0;
    ticks(255);
    chk("bp_ovr_before", overrun, 1'b0);
    tick();
    chk("bp_ovr_set", overrun, 1'b1);
    chk("bp_valid_held", sample_valid, 1'b1);
    chk("bp_data_held", sample_data, 8'hFF);
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    chk("bp_xfer_valid", sample_valid, 1'b0);
    chk("bp_xfer_ovr", overrun, 1'b0);

    // Asynchronous reset mid-window with a full buffer and overrun set
    pdm_in = 1'b1;
    wait_valid("rst_to1", n);
    ticks(256);
    chk("pre_rst_valid", sample_valid, 1'b1);
    chk("pre_rst_ovr", overrun, 1'b1);
    ticks(50);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_data", sample_data, 8'h00);
    chk("arst_valid", sample_valid, 1'b0);
    chk("arst_ovr", overrun, 1'b0);
    #1;
    rst = 1'b0;
    sample_ready = 1'b1;
    // Synchronisers restart from 0, so the first sample counts 0, leaving 255 = 0xFF.
    wait_valid("post_rst_to", n);
    chk("post_rst_latency", n, 259);
    chk("post_rst_data", sample_data, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pdm_decimator.md
# pdm_decimator

Reads the 1-bit pulse-density stream produced by the digital OTA comparator output and converts it into parallel sample words. It synchronises the bitstream and its drive-enable into the clock domain, counts ones over a fixed power-of-two window (accumulate-and-dump), and presents each result through a single-entry valid/ready output buffer. It sits between the OTA output pad and the digital readout logic.

## Interface
- OSR_LOG2, 8, log2 of window length in samples (window = 2^OSR_LOG2 cycles); must be ≥ OUT_W
- OUT_W, 8, width of result word
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  conversion enable; low = idle, partial window discarded
- pdm_in  in  1  OTA output bit (asynchronous to clk)
- pdm_drv  in  1  OTA output-driven flag (EN of the tristate; asynchronous to clk)
- sample_data  out  OUT_W  result of last completed window
- sample_valid  out  1  sample_data holds an unconsumed result
- sample_ready  in  1  consumer accepts sample_data when high with sample_valid
- overrun  out  1  sticky: a completed result was dropped because the buffer was full

## Operation
- pdm_in and pdm_drv each pass through a 2-flop synchroniser; all processing uses the synchronised copies (s_bit, s_drv).
- Effective sample per cycle: s_bit when s_drv=1; when s_drv=0, see Configuration. Last-driven register resets to 0 and updates whenever s_drv=1.
- States: IDLE, ACCUM, DUMP.
  - IDLE: sample counter and ones counter held at 0. en=1 → ACCUM.
  - ACCUM: each cycle ones += effective sample, count += 1. After sample 2^OSR_LOG2 is taken → DUMP. en=0 → IDLE, partial window discarded.
  - DUMP: registers the result and clears counters; the effective sample of this cycle is counted as sample 1 of the next window, so no samples are lost. en=1 → ACCUM; en=0 → IDLE. The result is still produced if en falls during DUMP.
- Result: ones ranges 0..2^OSR_LOG2 (OSR_LOG2+1 bits). result = ones >> (OSR_LOG2−OUT_W); a full count (all ones) saturates to 2^OUT_W−1.
- Output buffer:
  - Result completes and buffer is empty, or is being accepted this cycle (valid&ready) → load; sample_valid=1.
  - Result completes, valid=1 and ready=0 → result dropped; overrun set; buffered data unchanged.
  - Transfer (valid&ready) with no new result → sample_valid=0.
- overrun clears only on rst or on a transfer cycle. If a transfer and a new overrun coincide, set wins.
- sample_data is stable while sample_valid=1. A buffered result survives en=0.

## Timing
- Reset (async assert, released on clk): state IDLE; sample_data=0; sample_valid=0; overrun=0; synchronisers, counters and last-driven register at 0.
- Input-to-count latency: 2 cycles (synchroniser).
- en rising at edge N → first sample counted at edge N+1 (ACCUM). Window occupies 2^OSR_LOG2 consecutive counted cycles.
- sample_valid rises on the edge after DUMP. Result latency from last counted sample to valid is 2 cycles.
- Throughput: one result per 2^OSR_LOG2 cycles during continuous en.
- Handshake: transfer occurs on a rising edge where valid=1 and ready=1. ready is ignored while valid=0.

## Configuration
- PDM_DEC_HOLD_EN defined: undriven cycles (s_drv=0) use the last-driven value, modelling the OTA keeper.
- PDM_DEC_HOLD_EN undefined: undriven cycles count as 0. The last-driven register is not built.

## Test plan
- Defaults, en=1, pdm_in=1, pdm_drv=1 for 2 windows → two results of 0xFF (saturated), one every 256 cycles; overrun=0 with ready=1.
- Alternating 1/0, drv=1 → 0x80 per window; all-zero input → 0x00.
- pdm_in=1 for 64 cycles, then pdm_drv=0 for the rest of the window → 0xFF with PDM_DEC_HOLD_EN; 0x40 without.
- ready=0 across two window completions → first result is held in sample_data; overrun=1 after the second. One ready pulse → transfer occurs, valid=0, overrun=0.
- en dropped at sample 100 of a window and re-raised → no result from the partial window; next result reflects a fresh full window only.
- rst asserted mid-window with valid=1 → sample_data, valid and overrun are 0 immediately (asynchronous); resumes from IDLE.
